// File: rtl/counter_wait_minus1_if.sv
// Result-side bundle of the down-counting wait controller: both counter values,
// the captured difference W with its valid/ready handshake, and the sticky done flag.
interface counter_wait_minus1_if #(
  parameter int unsigned WIDTH = 32'd4
);
  logic             w_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] W;
  logic             w_valid;
  logic             done;

  modport master (
    input  w_ready,
    output a,
    output b,
    output W,
    output w_valid,
    output done
  );

  modport slave (
    output w_ready,
    input  a,
    input  b,
    input  W,
    input  w_valid,
    input  done
  );
endinterface

// File: rtl/counter_wait_minus1.sv
// Two down-counters that pause at programmable stop values; once both pause, a - b
// is captured into W and offered downstream, and acceptance releases both counters.
module counter_wait_minus1 #(
  parameter int unsigned WIDTH   = 32'd4,
  parameter int unsigned A_INIT  = 32'd15,
  parameter int unsigned A_STOP0 = 32'd12,
  parameter int unsigned A_STOP1 = 32'd9,
  parameter int unsigned B_INIT  = 32'd15,
  parameter int unsigned B_STOP0 = 32'd11,
  parameter int unsigned B_STOP1 = 32'd7,
  parameter int unsigned B_FINAL = 32'd7
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_wait_minus1_if.master bus
);

  localparam logic [WIDTH-1:0] A_INIT_W  = WIDTH'(A_INIT);
  localparam logic [WIDTH-1:0] A_STOP0_W = WIDTH'(A_STOP0);
  localparam logic [WIDTH-1:0] A_STOP1_W = WIDTH'(A_STOP1);
  localparam logic [WIDTH-1:0] B_INIT_W  = WIDTH'(B_INIT);
  localparam logic [WIDTH-1:0] B_STOP0_W = WIDTH'(B_STOP0);
  localparam logic [WIDTH-1:0] B_STOP1_W = WIDTH'(B_STOP1);
  localparam logic [WIDTH-1:0] B_FINAL_W = WIDTH'(B_FINAL);
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic is_stop(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] s0,
    input logic [WIDTH-1:0] s1
  );
    return (v == s0) || (v == s1);
  endfunction

  function automatic logic [WIDTH-1:0] mod_diff(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    return x - y;
  endfunction

  state_t           a_st_q, a_st_d;
  state_t           b_st_q, b_st_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_dec_s;
  logic [WIDTH-1:0] b_dec_s;
  logic             capture_s;
  logic             accept_s;
  logic             release_s;

  // Capture and accept are mutually exclusive: capture needs w_valid low, accept needs it high.
  always_comb begin
    a_dec_s   = a_q - ONE_W;
    b_dec_s   = b_q - ONE_W;
    capture_s = (a_st_q == ST_HOLD) && (b_st_q == ST_HOLD) && !w_valid_q && !done_q;
    accept_s  = w_valid_q && bus.w_ready;
    release_s = accept_s && (b_q != B_FINAL_W);
  end

  // Counter A: the stop test looks only at the freshly decremented value.
  always_comb begin
    a_d    = a_q;
    a_st_d = a_st_q;
    case (a_st_q)
      ST_RUN: begin
        a_d = a_dec_s;
        if (is_stop(a_dec_s, A_STOP0_W, A_STOP1_W)) begin
          a_st_d = ST_HOLD;
        end else begin
          a_st_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          a_st_d = ST_RUN;
        end else begin
          a_st_d = ST_HOLD;
        end
      end
      default: begin
        a_d    = a_q;
        a_st_d = ST_RUN;
      end
    endcase
  end

  // Counter B mirrors counter A with its own stop values.
  always_comb begin
    b_d    = b_q;
    b_st_d = b_st_q;
    case (b_st_q)
      ST_RUN: begin
        b_d = b_dec_s;
        if (is_stop(b_dec_s, B_STOP0_W, B_STOP1_W)) begin
          b_st_d = ST_HOLD;
        end else begin
          b_st_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          b_st_d = ST_RUN;
        end else begin
          b_st_d = ST_HOLD;
        end
      end
      default: begin
        b_d    = b_q;
        b_st_d = ST_RUN;
      end
    endcase
  end

  // Result path: W is kept after acceptance; accepting at b == B_FINAL ends the run.
  always_comb begin
    w_d       = w_q;
    w_valid_d = w_valid_q;
    done_d    = done_q;
    if (capture_s) begin
      w_d       = mod_diff(a_q, b_q);
      w_valid_d = 1'b1;
    end else if (accept_s) begin
      w_valid_d = 1'b0;
      if (b_q == B_FINAL_W) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      w_d = w_q;
    end
  end

  // Single state register for both counter FSMs and the result path; reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_st_q    <= ST_RUN;
      b_st_q    <= ST_RUN;
      a_q       <= A_INIT_W;
      b_q       <= B_INIT_W;
      w_q       <= ZERO_W;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      a_st_q    <= a_st_d;
      b_st_q    <= b_st_d;
      a_q       <= a_d;
      b_q       <= b_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.W       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_counter_wait_minus1.sv
// Directed bench: default run, wrap with modular difference, stop-equals-init,
// backpressure and reset during a pending handshake, all against hand-derived values.
module tb_counter_wait_minus1;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  counter_wait_minus1_if #(.WIDTH(4)) bus0 ();
  counter_wait_minus1_if #(.WIDTH(4)) bus1 ();
  counter_wait_minus1_if #(.WIDTH(4)) bus2 ();

  counter_wait_minus1 u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  counter_wait_minus1 #(
    .A_INIT (32'd1),
    .A_STOP0(32'd14),
    .B_STOP0(32'd1),
    .B_STOP1(32'd15),
    .B_FINAL(32'd15)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  counter_wait_minus1 #(
    .A_INIT (32'd12),
    .A_STOP0(32'd12),
    .A_STOP1(32'd12)
  ) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus0.w_ready = 1'b1;
    bus1.w_ready = 1'b1;
    bus2.w_ready = 1'b1;

    // Phase 1: default run (u0), wrap case (u1), stop equal to init (u2).
    do_reset();
    chk("rst a", bus0.a, 15);
    chk("rst b", bus0.b, 15);
    chk("rst W", bus0.W, 0);
    chk("rst valid", bus0.w_valid, 0);
    chk("rst done", bus0.done, 0);
    chk("rst u1 a", bus1.a, 1);
    chk("rst u2 a", bus2.a, 12);

    for (int e = 1; e <= 34; e++) begin
      tick();
      case (e)
        1: begin
          chk("e1 a", bus0.a, 14); chk("e1 b", bus0.b, 14);
          chk("u1 e1 a", bus1.a, 0); chk("u2 e1 a", bus2.a, 11);
        end
        2:  chk("u1 e2 wrap a", bus1.a, 15);
        3: begin
          chk("e3 a", bus0.a, 12); chk("e3 b", bus0.b, 12);
          chk("u1 e3 a", bus1.a, 14);
        end
        4: begin
          chk("e4 a", bus0.a, 12); chk("e4 b", bus0.b, 11);
          chk("e4 valid", bus0.w_valid, 0);
        end
        5: begin chk("e5 W", bus0.W, 1); chk("e5 valid", bus0.w_valid, 1); end
        6: begin
          chk("e6 valid", bus0.w_valid, 0); chk("e6 done", bus0.done, 0);
          chk("e6 a", bus0.a, 12); chk("e6 b", bus0.b, 11);
        end
        7:  begin chk("e7 a", bus0.a, 11); chk("e7 b", bus0.b, 10); end
        10: begin
          chk("e10 a", bus0.a, 9); chk("e10 b", bus0.b, 7);
          chk("e10 valid", bus0.w_valid, 0);
        end
        11: begin chk("e11 W", bus0.W, 2); chk("e11 valid", bus0.w_valid, 1); end
        12: begin
          chk("e12 done", bus0.done, 1); chk("e12 valid", bus0.w_valid, 0);
          chk("u2 e12 a", bus2.a, 0);
        end
        13: chk("u2 e13 wrap a", bus2.a, 15);
        14: begin
          chk("u1 e14 a", bus1.a, 14); chk("u1 e14 b", bus1.b, 1);
          chk("u1 e14 valid", bus1.w_valid, 0);
        end
        15: begin
          chk("u1 e15 W", bus1.W, 13); chk("u1 e15 valid", bus1.w_valid, 1);
          chk("u2 e15 a", bus2.a, 13);
        end
        16: begin
          chk("u1 e16 valid", bus1.w_valid, 0); chk("u1 e16 a", bus1.a, 14);
          chk("u2 e16 a", bus2.a, 12);
        end
        17: begin
          chk("u1 e17 a", bus1.a, 13); chk("u1 e17 b", bus1.b, 0);
          chk("u2 e17 a", bus2.a, 12); chk("u2 e17 W", bus2.W, 1);
          chk("u2 e17 valid", bus2.w_valid, 1);
        end
        18: chk("u1 e18 wrap b", bus1.b, 15);
        21: begin
          chk("u1 e21 a", bus1.a, 9); chk("u1 e21 b", bus1.b, 15);
          chk("u1 e21 valid", bus1.w_valid, 0);
        end
        22: begin chk("u1 e22 W", bus1.W, 10); chk("u1 e22 valid", bus1.w_valid, 1); end
        23: begin chk("u1 e23 done", bus1.done, 1); chk("u1 e23 valid", bus1.w_valid, 0); end
        34: begin
          chk("e34 a", bus0.a, 9); chk("e34 b", bus0.b, 7);
          chk("e34 valid", bus0.w_valid, 0); chk("e34 done", bus0.done, 1);
          chk("e34 W", bus0.W, 2); chk("u1 e34 W", bus1.W, 10);
        end
        default: ;
      endcase
    end

    // Phase 2: backpressure on u0 from edge 5 through edge 14.
    bus0.w_ready = 1'b0;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e >= 5 && e <= 14) begin
        chk($sformatf("bp e%0d W", e), bus0.W, 1);
        chk($sformatf("bp e%0d valid", e), bus0.w_valid, 1);
        chk($sformatf("bp e%0d a", e), bus0.a, 12);
        chk($sformatf("bp e%0d b", e), bus0.b, 11);
      end else if (e == 15) begin
        chk("bp e15 valid", bus0.w_valid, 0);
        chk("bp e15 a", bus0.a, 12);
      end else if (e == 16) begin
        chk("bp e16 a", bus0.a, 11);
        chk("bp e16 b", bus0.b, 10);
      end
      if (e == 14) bus0.w_ready = 1'b1;
    end

    // Phase 3: reset lands on the edge that would complete a handshake.
    do_reset();
    for (int e = 1; e <= 5; e++) tick();
    chk("rm pre valid", bus0.w_valid, 1);
    reset = 1'b0;
    tick();
    chk("rm a", bus0.a, 15);
    chk("rm b", bus0.b, 15);
    chk("rm W", bus0.W, 0);
    chk("rm valid", bus0.w_valid, 0);
    chk("rm done", bus0.done, 0);
    reset = 1'b1;
    tick();
    chk("rm e1 a", bus0.a, 14);
    chk("rm e1 b", bus0.b, 14);
    chk("rm e1 done", bus0.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_wait_minus1.md
Name: counter_wait_minus1

Overview:
- Down-counting counterpart to the up-counting two-counter wait controller.
- Two WIDTH-bit counters decrement from preset values and each pauses at its own programmable stop points.
- When both counters are paused, the block captures the difference a - b into W and offers it on a valid/ready handshake.
- The downstream consumer's acceptance releases both counters. The run ends at a final b value.

Parameters:
- WIDTH, 4, counter and W width
- A_INIT, 15, value of a after reset
- A_STOP0, 12, first stop value for a
- A_STOP1, 9, second stop value for a
- B_INIT, 15, value of b after reset
- B_STOP0, 11, first stop value for b
- B_STOP1, 7, second stop value for b
- B_FINAL, 7, b value at which an accepted W ends the run

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- w_ready  input  1  consumer accepts W when high together with w_valid
- a  output  WIDTH  counter A value
- b  output  WIDTH  counter B value
- W  output  WIDTH  captured difference (a - b) mod 2^WIDTH
- w_valid  output  1  W holds an unaccepted result
- done  output  1  run finished; sticky until reset

Behaviour:
- Reset (reset==0 at a posedge):
  - a=A_INIT, b=B_INIT, W=0, w_valid=0, done=0.
  - Both counter FSMs go to RUN.
  - Reset overrides every other event, including a pending handshake.
- Counter FSM, one per counter, states RUN and HOLD. Counter A is described; counter B is identical with its own parameters.
  - RUN: each posedge, a <= a-1, wrapping 0 -> 2^WIDTH-1. If the new value equals A_STOP0 or A_STOP1, the FSM goes to HOLD on the same edge, so a rests at the stop value.
  - HOLD: a does not change. The FSM stays in HOLD until a release.
  - The stop check uses only the post-decrement value. A_INIT equal to a stop value therefore does not stop immediately; the counter stops there after a full wrap.
- Capture: on a posedge where both FSMs are in HOLD and w_valid==0 and done==0:
  - W <= (a - b) mod 2^WIDTH.
  - w_valid <= 1.
  - Latency: one cycle after the later counter reaches HOLD.
- Handshake: on a posedge with w_valid==1 and w_ready==1:
  - w_valid <= 0.
  - If b==B_FINAL: done <= 1. Both FSMs stay in HOLD and no further captures occur.
  - Otherwise: both FSMs go to RUN and decrement again from the next edge.
  - W keeps its last value after acceptance.
- Backpressure: while w_valid==1 and w_ready==0, W, a and b are frozen and w_valid stays high.
- w_ready is ignored while w_valid==0.
- Simultaneous arrival: both counters may reach HOLD on the same edge; capture then happens on the following edge.
- Unequal arrival: a counter that reaches HOLD first waits indefinitely for the other counter.
- No capture can occur on the same edge as a handshake, because capture requires w_valid==0 beforehand.
- Subtraction is modular WIDTH-bit, with no sign and no saturation.

Test Plan:
- Default parameters, w_ready=1 held, reset low for 2 cycles then high:
  - Edges 1-3: a 14,13,12, then HOLD.
  - Edges 1-4: b 14,13,12,11, then HOLD.
  - Edge 5: W=1, w_valid=1.
  - Edge 6: accepted, w_valid=0, both RUN.
- Continue the previous run:
  - Edges 7-10: a reaches 9 and b reaches 7.
  - Edge 11: W=2, w_valid=1.
  - Edge 12: done=1, w_valid=0.
  - Afterwards: a=9, b=7 frozen for 20+ cycles; w_valid stays 0.
- Backpressure: w_ready=0 from edge 5 to edge 14 -> W=1, w_valid=1, a=12, b=11 stable throughout. Raise w_ready at edge 15 -> w_valid=0 at edge 15 and a=11 at edge 16.
- Wrap and modular difference: override A_INIT=1, A_STOP0=14, B_STOP0=1 -> a goes 0 then 15 then 14 and holds. W = (14-1) = 13, then later cases wrap similarly; check a=0->15 with no glitch and no early stop.
- Reset mid-operation: drive reset=0 on the edge where w_valid==1 and w_ready==1 -> next state is a=15, b=15, W=0, w_valid=0, done=0, both RUN; no done assertion.
- Stop equal to init: override A_INIT=12, A_STOP0=12, A_STOP1=12 -> a stops at 12 only after 16 decrements, not at edge 1.
